// File: rtl/traffic_pkg.sv
// Shared light codes, lamp patterns, monitor state and fault codes for the
// traffic light monitor and its per-direction channel checkers.
package traffic_pkg;

    localparam logic [1:0] GREEN   = 2'b00;
    localparam logic [1:0] YELLOW  = 2'b01;
    localparam logic [1:0] RED     = 2'b10;
    localparam logic [1:0] INVALID = 2'b11;

    localparam logic [2:0] LAMP_OFF    = 3'b000;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    typedef enum logic {
        NORMAL = 1'b0,
        FAULT  = 1'b1
    } statetype;

    typedef enum logic [2:0] {
        FC_NONE         = 3'd0,
        FC_INVALID      = 3'd1,
        FC_CONFLICT     = 3'd2,
        FC_ILLEGAL      = 3'd3,
        FC_SHORT_YELLOW = 3'd4
    } fault_code_t;

    function automatic logic [2:0] decode_light(input logic [1:0] code);
        logic [2:0] lamp;
        case (code)
            GREEN:   lamp = LAMP_GREEN;
            YELLOW:  lamp = LAMP_YELLOW;
            RED:     lamp = LAMP_RED;
            default: lamp = LAMP_OFF;
        endcase
        return lamp;
    endfunction

    // Each light may hold, or advance one step around G -> Y -> R -> G.
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        logic ok;
        case (prev)
            GREEN:   ok = (cur == GREEN)  || (cur == YELLOW);
            YELLOW:  ok = (cur == YELLOW) || (cur == RED);
            RED:     ok = (cur == RED)    || (cur == GREEN);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light-code link between the intersection controller (master) and the monitor (slave).
// la/lb/clear_fault are level signals sampled on every clock; there is no valid/ready handshake.
interface traffic_light_monitor_if;

    logic [1:0] la;
    logic [1:0] lb;
    logic       clear_fault;
    logic [2:0] lamp_a;
    logic [2:0] lamp_b;
    logic       fault;
    logic [2:0] fault_code;
    logic       state_dbg;

    modport master (
        output la, lb, clear_fault,
        input  lamp_a, lamp_b, fault, fault_code, state_dbg
    );

    modport slave (
        input  la, lb, clear_fault,
        output lamp_a, lamp_b, fault, fault_code, state_dbg
    );

endinterface

// File: rtl/light_channel_checker.sv
// One direction's input history: previous code, consecutive-yellow count and
// the per-channel violation flags derived from them.
module light_channel_checker
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] code_i,
    input  logic       restart_i,
    output logic [2:0] lamp_o,
    output logic       invalid_o,
    output logic       illegal_o,
    output logic       short_yellow_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_Y   = CNT_W'(MIN_YELLOW);

    logic [1:0]       code_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] ycnt_q;
    logic [CNT_W-1:0] ycnt_d;

    always_comb begin
        ycnt_d = '0;
        if (code_i == YELLOW) begin
            ycnt_d = (ycnt_q == CNT_MAX) ? ycnt_q : ycnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            code_q       <= RED;
            prev_valid_q <= 1'b0;
            ycnt_q       <= '0;
        end else begin
            code_q       <= code_i;
            prev_valid_q <= ~restart_i;
            ycnt_q       <= ycnt_d;
        end
    end

    assign lamp_o    = decode_light(code_i);
    assign invalid_o = (code_i == INVALID);
    assign illegal_o = prev_valid_q && !legal_step(code_q, code_i);
    // ycnt_q counts yellows already registered, i.e. how long yellow was shown.
    assign short_yellow_o = prev_valid_q && (code_q == YELLOW) && (code_i == RED)
                            && (ycnt_q < MIN_Y);

endmodule

// File: rtl/traffic_light_monitor.sv
// Light-code consumer: decodes lamps, latches the first safety violation and
// flashes red on both directions until an operator clears the fault.
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_YELLOW = 1,
    parameter int unsigned FLASH_HALF = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    traffic_light_monitor_if.slave  mon
);

    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(2 * FLASH_HALF - 1);
    localparam logic [CNT_W-1:0] FLASH_ON   = CNT_W'(FLASH_HALF);

    statetype         state_q, state_d;
    fault_code_t      code_q, code_d, viol_code;
    logic [2:0]       lamp_a_q, lamp_a_d, lamp_b_q, lamp_b_d;
    logic [CNT_W-1:0] flash_q, flash_d;
    logic [2:0]       dec_a, dec_b;
    logic             inv_a, inv_b, ill_a, ill_b, sy_a, sy_b;
    logic             restart;

    light_channel_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_chk_a (
        .clk(clk), .reset(reset), .code_i(mon.la), .restart_i(restart),
        .lamp_o(dec_a), .invalid_o(inv_a), .illegal_o(ill_a), .short_yellow_o(sy_a)
    );

    light_channel_checker #(.MIN_YELLOW(MIN_YELLOW), .CNT_W(CNT_W)) u_chk_b (
        .clk(clk), .reset(reset), .code_i(mon.lb), .restart_i(restart),
        .lamp_o(dec_b), .invalid_o(inv_b), .illegal_o(ill_b), .short_yellow_o(sy_b)
    );

    always_comb begin
        viol_code = FC_NONE;
        if (inv_a || inv_b) begin
            viol_code = FC_INVALID;
        end else if ((mon.la != RED) && (mon.lb != RED)) begin
            viol_code = FC_CONFLICT;
        end else if (ill_a || ill_b) begin
            viol_code = FC_ILLEGAL;
        end else if (sy_a || sy_b) begin
            viol_code = FC_SHORT_YELLOW;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        lamp_a_d = lamp_a_q;
        lamp_b_d = lamp_b_q;
        flash_d  = flash_q;
        restart  = 1'b0;
        case (state_q)
            NORMAL: begin
                if (viol_code != FC_NONE) begin
                    state_d  = FAULT;
                    code_d   = viol_code;
                    lamp_a_d = LAMP_RED;
                    lamp_b_d = LAMP_RED;
                    flash_d  = '0;
                end else begin
                    lamp_a_d = dec_a;
                    lamp_b_d = dec_b;
                end
            end
            FAULT: begin
                if (mon.clear_fault && (mon.la == RED) && (mon.lb == RED)) begin
                    state_d  = NORMAL;
                    code_d   = FC_NONE;
                    lamp_a_d = dec_a;
                    lamp_b_d = dec_b;
                    flash_d  = '0;
                    restart  = 1'b1;
                end else begin
                    // flash_d counts cycles since detection modulo two half-periods.
                    flash_d  = (flash_q == FLASH_LAST) ? '0 : flash_q + 1'b1;
                    lamp_a_d = (flash_d < FLASH_ON) ? LAMP_RED : LAMP_OFF;
                    lamp_b_d = (flash_d < FLASH_ON) ? LAMP_RED : LAMP_OFF;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= NORMAL;
            code_q   <= FC_NONE;
            lamp_a_q <= LAMP_RED;
            lamp_b_q <= LAMP_RED;
            flash_q  <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            lamp_a_q <= lamp_a_d;
            lamp_b_q <= lamp_b_d;
            flash_q  <= flash_d;
        end
    end

    assign mon.lamp_a     = lamp_a_q;
    assign mon.lamp_b     = lamp_b_q;
    assign mon.fault      = (state_q == FAULT);
    assign mon.fault_code = code_q;
    assign mon.state_dbg  = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: two instances (MIN_YELLOW 1 and 2)
// share one stimulus stream and are checked against a rule-level model.
module tb_traffic_light_monitor;

    localparam int G  = 0;
    localparam int Y  = 1;
    localparam int R  = 2;
    localparam int IV = 3;
    localparam int FH = 4;

    logic clk = 1'b0;
    logic rst;

    traffic_light_monitor_if mon0 ();
    traffic_light_monitor_if mon1 ();

    traffic_light_monitor #(.MIN_YELLOW(1), .FLASH_HALF(FH), .CNT_W(8)) dut0 (
        .clk(clk), .reset(rst), .mon(mon0)
    );

    traffic_light_monitor #(.MIN_YELLOW(2), .FLASH_HALF(FH), .CNT_W(8)) dut1 (
        .clk(clk), .reset(rst), .mon(mon1)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Rule-level model: lamps as 1<<code, legality as "hold or advance one step".
    int min_y [2] = '{1, 2};
    int m_flt [2], m_code [2], m_fcnt [2], m_prev_ok [2];
    int m_pa [2], m_pb [2], m_ya [2], m_yb [2];
    int m_lamp_a [2], m_lamp_b [2];
    bit m_live = 1'b0;
    int ma, mb, mv;
    bit mclr, cleared;
    logic [9:0] exp_q0[$];
    logic [9:0] exp_q1[$];

    function automatic int lamp_of(input int c);
        return (c < 3) ? (1 << c) : 0;
    endfunction

    function automatic bit step_ok(input int p, input int c);
        return (c == p) || (c == (p + 1) % 3);
    endfunction

    function automatic int viol(input int k, input int a, input int b);
        if (a == IV || b == IV) return 1;
        if (a != R && b != R) return 2;
        if (m_prev_ok[k] != 0 && (!step_ok(m_pa[k], a) || !step_ok(m_pb[k], b))) return 3;
        if (m_prev_ok[k] != 0 &&
            ((m_pa[k] == Y && a == R && m_ya[k] < min_y[k]) ||
             (m_pb[k] == Y && b == R && m_yb[k] < min_y[k]))) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin
        ma   = int'(mon0.la);
        mb   = int'(mon0.lb);
        mclr = mon0.clear_fault;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_flt[k] = 0; m_code[k] = 0; m_fcnt[k] = 0; m_prev_ok[k] = 0;
                m_pa[k] = R; m_pb[k] = R; m_ya[k] = 0; m_yb[k] = 0;
                m_lamp_a[k] = 4; m_lamp_b[k] = 4;
            end else if (m_live) begin
                cleared = 1'b0;
                if (m_flt[k] == 0) begin
                    mv = viol(k, ma, mb);
                    if (mv != 0) begin
                        m_flt[k] = 1; m_code[k] = mv; m_fcnt[k] = 0;
                        m_lamp_a[k] = 4; m_lamp_b[k] = 4;
                    end else begin
                        m_lamp_a[k] = lamp_of(ma); m_lamp_b[k] = lamp_of(mb);
                    end
                end else if (mclr && ma == R && mb == R) begin
                    m_flt[k] = 0; m_code[k] = 0; cleared = 1'b1;
                    m_lamp_a[k] = lamp_of(ma); m_lamp_b[k] = lamp_of(mb);
                end else begin
                    m_fcnt[k]++;
                    m_lamp_a[k] = ((m_fcnt[k] / FH) % 2 == 0) ? 4 : 0;
                    m_lamp_b[k] = m_lamp_a[k];
                end
                m_ya[k] = (ma == Y) ? m_ya[k] + 1 : 0;
                m_yb[k] = (mb == Y) ? m_yb[k] + 1 : 0;
                m_pa[k] = ma;
                m_pb[k] = mb;
                m_prev_ok[k] = cleared ? 0 : 1;
            end
        end
        if (rst) m_live = 1'b1;
        if (m_live) begin
            exp_q0.push_back({3'(m_lamp_a[0]), 3'(m_lamp_b[0]), 1'(m_flt[0]), 3'(m_code[0])});
            exp_q1.push_back({3'(m_lamp_a[1]), 3'(m_lamp_b[1]), 1'(m_flt[1]), 3'(m_code[1])});
        end
    end

    task automatic cmp_inst(input string p, input logic [9:0] e, input logic [2:0] la_v,
                            input logic [2:0] lb_v, input logic f_v, input logic [2:0] c_v);
        check({p, "_lamp_a"}, la_v, e[9:7]);
        check({p, "_lamp_b"}, lb_v, e[6:4]);
        check({p, "_fault"}, f_v, e[3]);
        check({p, "_code"}, c_v, e[2:0]);
    endtask

    always @(negedge clk) begin
        if (exp_q0.size() > 0)
            cmp_inst("cyc_d0", exp_q0.pop_front(), mon0.lamp_a, mon0.lamp_b, mon0.fault, mon0.fault_code);
        if (exp_q1.size() > 0)
            cmp_inst("cyc_d1", exp_q1.pop_front(), mon1.lamp_a, mon1.lamp_b, mon1.fault, mon1.fault_code);
    end

    task automatic step(input int a, input int b, input bit c, input bit r);
        @(negedge clk);
        mon0.la = 2'(a); mon1.la = 2'(a);
        mon0.lb = 2'(b); mon1.lb = 2'(b);
        mon0.clear_fault = c; mon1.clear_fault = c;
        rst = r;
        @(posedge clk);
        #1;
    endtask

    // Hand-computed expectations, applied both to the DUT and to the model.
    task automatic expect_st(input int k, input string tag, input int ea, input int eb,
                             input int ef, input int ec);
        logic [2:0] la_v, lb_v, c_v;
        logic f_v;
        if (k == 0) begin
            la_v = mon0.lamp_a; lb_v = mon0.lamp_b; f_v = mon0.fault; c_v = mon0.fault_code;
        end else begin
            la_v = mon1.lamp_a; lb_v = mon1.lamp_b; f_v = mon1.fault; c_v = mon1.fault_code;
        end
        check({tag, "_lamp_a"}, la_v, ea);
        check({tag, "_lamp_b"}, lb_v, eb);
        check({tag, "_fault"}, f_v, ef);
        check({tag, "_code"}, c_v, ec);
        check({tag, "_model_lamp_a"}, m_lamp_a[k], ea);
        check({tag, "_model_code"}, m_code[k], ec);
    endtask

    int t1_a [6]  = '{G, Y, R, R, R, R};
    int t1_b [6]  = '{R, R, R, G, Y, R};
    int t1_ea [6] = '{1, 2, 4, 4, 4, 4};
    int t1_eb [6] = '{4, 4, 4, 1, 2, 4};

    initial begin
        rst = 1'b1;
        mon0.la = 2'(R); mon1.la = 2'(R);
        mon0.lb = 2'(R); mon1.lb = 2'(R);
        mon0.clear_fault = 1'b0; mon1.clear_fault = 1'b0;

        step(R, R, 0, 1);
        expect_st(0, "rst_d0", 4, 4, 0, 0);
        expect_st(1, "rst_d1", 4, 4, 0, 0);

        for (int i = 0; i < 6; i++) begin
            step(t1_a[i], t1_b[i], 0, 0);
            expect_st(0, $sformatf("t1_s%0d", i), t1_ea[i], t1_eb[i], 0, 0);
            if (i == 2) expect_st(1, "t1_short_d1", 4, 4, 1, 4);
        end

        step(G, G, 0, 0);
        expect_st(0, "t2_det", 4, 4, 1, 2);
        for (int i = 0; i < 3; i++) step(R, R, 0, 0);
        expect_st(0, "t2_on3", 4, 4, 1, 2);
        step(IV, G, 0, 0);
        expect_st(0, "t2_off_ign", 0, 0, 1, 2);
        for (int i = 0; i < 3; i++) step(R, R, 0, 0);
        expect_st(0, "t2_off7", 0, 0, 1, 2);
        step(R, R, 0, 0);
        expect_st(0, "t2_on8", 4, 4, 1, 2);

        step(G, R, 1, 0);
        expect_st(0, "t6_clr_ign", 4, 4, 1, 2);
        step(R, R, 1, 0);
        expect_st(0, "t6_clr", 4, 4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(t1_a[i], t1_b[i], 0, 0);
            expect_st(0, $sformatf("t6_seq%0d", i), t1_ea[i], t1_eb[i], 0, 0);
        end

        step(R, R, 0, 1);
        step(G, R, 0, 0);
        step(R, R, 0, 0);
        expect_st(0, "t3_illegal", 4, 4, 1, 3);

        step(G, R, 0, 1);
        expect_st(0, "t3_rst_g", 4, 4, 0, 0);
        step(R, R, 0, 0);
        expect_st(0, "t3_post_rst", 4, 4, 0, 0);

        step(R, R, 0, 1);
        step(G, R, 0, 0);
        step(Y, R, 0, 0);
        step(R, R, 0, 0);
        expect_st(0, "t4_y1_d0", 4, 4, 0, 0);
        expect_st(1, "t4_y1_d1", 4, 4, 1, 4);

        step(R, R, 0, 1);
        step(G, R, 0, 0);
        step(Y, R, 0, 0);
        step(Y, R, 0, 0);
        step(R, R, 0, 0);
        expect_st(1, "t4_y2_d1", 4, 4, 0, 0);

        step(R, R, 0, 1);
        step(IV, G, 0, 0);
        expect_st(0, "t5_inv_a", 4, 4, 1, 1);
        step(R, R, 0, 1);
        step(R, IV, 0, 0);
        expect_st(0, "t5_inv_b", 4, 4, 1, 1);

        step(R, R, 0, 1);
        step(G, R, 1, 0);
        expect_st(0, "clr_normal", 1, 4, 0, 0);
        step(G, G, 1, 0);
        expect_st(0, "clr_normal_det", 4, 4, 1, 2);
        step(R, R, 0, 0);
        step(R, R, 0, 0);
        step(Y, G, 0, 1);
        expect_st(0, "t6_rst_mid", 4, 4, 0, 0);
        expect_st(1, "t6_rst_mid_d1", 4, 4, 0, 0);
        step(R, R, 0, 0);

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
